// File: rtl/paddle_ctrl_if.sv
// Pixel-stream and paddle-geometry bundle between the video pipeline and the
// paddle controller. The video side (master) supplies the pixel being drawn.
// The paddle controller (slave) publishes geometry, direction, obstacle flags
// and the frame tick.
interface paddle_ctrl_if;
   logic [9:0] drawX;
   logic [9:0] drawY;
   logic       bit_on;
   logic [9:0] paddle_x;
   logic [9:0] paddle_y;
   logic [9:0] paddle_s;
   logic       dir_up;
   logic       top_blocked;
   logic       bottom_blocked;
   logic       frame_tick;

   modport master (
      output drawX, drawY, bit_on,
      input  paddle_x, paddle_y, paddle_s, dir_up,
      input  top_blocked, bottom_blocked, frame_tick
   );

   modport slave (
      input  drawX, drawY, bit_on,
      output paddle_x, paddle_y, paddle_s, dir_up,
      output top_blocked, bottom_blocked, frame_tick
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle controller. It moves the paddle once per frame in one of four modes:
// auto-bounce, manual keys, ball tracking or hold. Obstacle pixels seen just
// above or below the paddle during a frame act as walls on the next tick.
// Everything runs on vga_clk. frame_clk is only sampled through a synchroniser.
module paddle_ctrl #(
   parameter int X_POS    = 20,
   parameter int HALF_H   = 40,
   parameter int HALF_W   = 4,
   parameter int Y_CENTER = 240,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 479,
   parameter int STEP     = 1,
   parameter int DEADBAND = 4
) (
   input  logic          vga_clk,
   input  logic          Reset,
   input  logic          frame_clk,
   input  logic [1:0]    mode,
   input  logic          key_up,
   input  logic          key_down,
   input  logic [9:0]    ball_y,
   paddle_ctrl_if.slave  vid
);

   localparam logic [10:0] LIM_TOP = 11'(Y_MIN + HALF_H);
   localparam logic [10:0] LIM_BOT = 11'(Y_MAX - HALF_H);
   localparam logic [10:0] STEP_W  = 11'(STEP);
   localparam logic [10:0] DB_W    = 11'(DEADBAND);
   localparam logic [10:0] HH_W    = 11'(HALF_H);
   localparam logic [10:0] XP_W    = 11'(X_POS);
   localparam logic [10:0] HW_W    = 11'(HALF_W);
   localparam logic [10:0] YC_W    = 11'(Y_CENTER);

   typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;

   dir_t        state_q, state_d;
   logic [10:0] y_q, y_d;
   logic        s1, s2, s3;
   logic        primed, armed;
   logic        tick_q;
   logic        acc_top, acc_bot;
   logic        top_blk_q, bot_blk_q;
   logic        want_up, want_dn;

   logic [10:0] draw_x11, draw_y11, ball_y11;
   logic        in_window, hit_top, hit_bot;

   // Rows are compared in 11 bits, with the offset added on the drawY side,
   // so a row above the screen can never match.
   assign draw_x11  = {1'b0, vid.drawX};
   assign draw_y11  = {1'b0, vid.drawY};
   assign ball_y11  = {1'b0, ball_y};
   assign in_window = (draw_x11 + HW_W >= XP_W) && (draw_x11 <= XP_W + HW_W);
   assign hit_top   = vid.bit_on && in_window && (draw_y11 + HH_W + 11'd1 == y_q);
   assign hit_bot   = vid.bit_on && in_window && (draw_y11 == y_q + HH_W + 11'd1);

   // Synchronise frame_clk and emit a one-cycle tick on each rising edge.
   // armed stays low until frame_clk has been seen low after reset, so a
   // strobe held high through reset release does not produce a tick.
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         primed <= 1'b0;
         armed  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         s1     <= frame_clk;
         s2     <= s1;
         s3     <= s2;
         primed <= 1'b1;
         armed  <= armed | (primed & ~s1 & ~s2);
         tick_q <= s2 & ~s3 & armed;
      end
   end

   // Gather obstacle hits over a frame and publish them as blocked flags at
   // the tick. A hit in the tick cycle itself belongs to the new frame.
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         acc_top   <= 1'b0;
         acc_bot   <= 1'b0;
         top_blk_q <= 1'b0;
         bot_blk_q <= 1'b0;
      end else if (tick_q) begin
         top_blk_q <= acc_top;
         bot_blk_q <= acc_bot;
         acc_top   <= hit_top;
         acc_bot   <= hit_bot;
      end else begin
         acc_top   <= acc_top | hit_top;
         acc_bot   <= acc_bot | hit_bot;
      end
   end

   // Paddle position and direction register.
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= DOWN;
         y_q     <= YC_W;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
      end
   end

   // Per-frame move decision. The frame's accumulated hits act as the walls.
   // Up-moves compare against LIM_TOP+STEP so the subtraction never wraps.
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      want_up = 1'b0;
      want_dn = 1'b0;
      if (tick_q) begin
         case (mode)
            2'd0: begin
               if (state_q == DOWN) begin
                  if (acc_bot) begin
                     state_d = UP;
                  end else if (y_q + STEP_W >= LIM_BOT) begin
                     y_d     = LIM_BOT;
                     state_d = UP;
                  end else begin
                     y_d = y_q + STEP_W;
                  end
               end else begin
                  if (acc_top) begin
                     state_d = DOWN;
                  end else if (y_q <= LIM_TOP + STEP_W) begin
                     y_d     = LIM_TOP;
                     state_d = DOWN;
                  end else begin
                     y_d = y_q - STEP_W;
                  end
               end
            end
            2'd1: begin
               want_up = key_up & ~key_down;
               want_dn = key_down & ~key_up;
            end
            2'd2: begin
               want_dn = ball_y11 > y_q + DB_W;
               want_up = ball_y11 + DB_W < y_q;
            end
            default: begin
            end
         endcase
         if (want_up) begin
            state_d = UP;
            if (!acc_top) begin
               y_d = (y_q <= LIM_TOP + STEP_W) ? LIM_TOP : y_q - STEP_W;
            end
         end else if (want_dn) begin
            state_d = DOWN;
            if (!acc_bot) begin
               y_d = (y_q + STEP_W >= LIM_BOT) ? LIM_BOT : y_q + STEP_W;
            end
         end
      end
   end

   assign vid.paddle_x       = 10'(X_POS);
   assign vid.paddle_y       = y_q[9:0];
   assign vid.paddle_s       = 10'(HALF_H);
   assign vid.dir_up         = (state_q == UP);
   assign vid.top_blocked    = top_blk_q;
   assign vid.bottom_blocked = bot_blk_q;
   assign vid.frame_tick     = tick_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Testbench for paddle_ctrl. A frame-level reference model predicts each tick's
// outcome and queues it. A monitor pops the queue whenever the DUT ticks.
module tb_paddle_ctrl;

   localparam int X_POS    = 20;
   localparam int HALF_H   = 40;
   localparam int HALF_W   = 4;
   localparam int Y_CENTER = 240;
   localparam int STEP     = 1;
   localparam int DEADBAND = 4;
   localparam int LIM_TOP  = 40;
   localparam int LIM_BOT  = 439;

   logic       vga_clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [1:0] mode;
   logic       key_up, key_down;
   logic [9:0] ball_y;

   paddle_ctrl_if vid();

   paddle_ctrl dut (
      .vga_clk  (vga_clk),
      .Reset    (Reset),
      .frame_clk(frame_clk),
      .mode     (mode),
      .key_up   (key_up),
      .key_down (key_down),
      .ball_y   (ball_y),
      .vid      (vid)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int y;
      int dir;
      int topb;
      int botb;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   tick_seen = 0;

   int my, mdir, mtop, mbot, acc_t, acc_b;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      my    = Y_CENTER;
      mdir  = 0;
      mtop  = 0;
      mbot  = 0;
      acc_t = 0;
      acc_b = 0;
   endtask

   task automatic modelPixel(input int x, input int y, input int b);
      if (b != 0 && x >= X_POS - HALF_W && x <= X_POS + HALF_W) begin
         if (y == my - HALF_H - 1) acc_t = 1;
         if (y == my + HALF_H + 1) acc_b = 1;
      end
   endtask

   task automatic modelFrame(input int m, input int ku, input int kd, input int ball);
      int   bt, bb, want;
      exp_t e;
      bt   = acc_t;
      bb   = acc_b;
      want = 0;
      if (m == 0) begin
         if (mdir == 0) begin
            if (bb != 0) mdir = 1;
            else if (my + STEP >= LIM_BOT) begin my = LIM_BOT; mdir = 1; end
            else my = my + STEP;
         end else begin
            if (bt != 0) mdir = 0;
            else if (my - STEP <= LIM_TOP) begin my = LIM_TOP; mdir = 0; end
            else my = my - STEP;
         end
      end else if (m == 1) begin
         if (ku != 0 && kd == 0) want = -1;
         else if (kd != 0 && ku == 0) want = 1;
      end else if (m == 2) begin
         if (ball > my + DEADBAND) want = 1;
         else if (ball + DEADBAND < my) want = -1;
      end
      if (want < 0) begin
         mdir = 1;
         if (bt == 0) my = (my - STEP < LIM_TOP) ? LIM_TOP : my - STEP;
      end else if (want > 0) begin
         mdir = 0;
         if (bb == 0) my = (my + STEP > LIM_BOT) ? LIM_BOT : my + STEP;
      end
      mtop  = bt;
      mbot  = bb;
      acc_t = 0;
      acc_b = 0;
      e.y    = my;
      e.dir  = mdir;
      e.topb = mtop;
      e.botb = mbot;
      sb.push_back(e);
   endtask

   // One frame: optional pixel traffic, then a frame_clk pulse and a bounded
   // wait for the monitor to consume the predicted outcome.
   // pixmode 0 = none, 1 = random near the paddle edges, 2 = one pixel just below.
   task automatic applyStimulus(input int m, input int ku, input int kd, input int ball,
                                input int pixmode);
      int x, y, b;
      bit done;
      @(posedge vga_clk); #1;
      mode     = 2'(m);
      key_up   = ku[0];
      key_down = kd[0];
      ball_y   = 10'(ball);
      if (pixmode == 1) begin
         repeat (16) begin
            x = X_POS - 6 + int'($urandom_range(0, 12));
            case ($urandom_range(0, 2))
               0:       y = my - HALF_H - 1;
               1:       y = my + HALF_H + 1;
               default: y = int'($urandom_range(0, 479));
            endcase
            if (y < 0) y = 0;
            b = int'($urandom_range(0, 1));
            vid.drawX  = 10'(x);
            vid.drawY  = 10'(y);
            vid.bit_on = b[0];
            modelPixel(x, y, b);
            @(posedge vga_clk); #1;
         end
      end else if (pixmode == 2) begin
         vid.drawX  = 10'(X_POS);
         vid.drawY  = 10'(my + HALF_H + 1);
         vid.bit_on = 1'b1;
         modelPixel(X_POS, my + HALF_H + 1, 1);
         @(posedge vga_clk); #1;
      end
      vid.bit_on = 1'b0;
      vid.drawX  = 10'd0;
      vid.drawY  = 10'd0;
      @(posedge vga_clk); #1;
      modelFrame(m, ku, kd, ball);
      frame_clk = 1'b1;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(posedge vga_clk); #1;
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) begin
         total++;
         bad++;
         $display("[TB] FAIL tick_timeout: got no tick, expected one within 20 cycles");
         sb.delete();
      end
      frame_clk = 1'b0;
      repeat (4) @(posedge vga_clk);
      #1;
   endtask

   task automatic doReset();
      Reset      = 1'b1;
      frame_clk  = 1'b0;
      vid.bit_on = 1'b0;
      repeat (2) @(posedge vga_clk);
      #1 Reset = 1'b0;
      modelReset();
      sb.delete();
      repeat (3) @(posedge vga_clk);
      #1;
   endtask

   // Monitor: the cycle after every tick, compare the DUT against the next prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge vga_clk);
         if (vid.frame_tick === 1'b1) begin
            tick_seen++;
            @(negedge vga_clk);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_tick: got tick, expected none");
            end else begin
               e = sb.pop_front();
               checkOutput("paddle_y", int'(vid.paddle_y), e.y);
               checkOutput("dir_up", int'(vid.dir_up), e.dir);
               checkOutput("top_blocked", int'(vid.top_blocked), e.topb);
               checkOutput("bottom_blocked", int'(vid.bottom_blocked), e.botb);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seen0;
      Reset      = 1'b1;
      frame_clk  = 1'b0;
      mode       = 2'd0;
      key_up     = 1'b0;
      key_down   = 1'b0;
      ball_y     = 10'd0;
      vid.drawX  = 10'd0;
      vid.drawY  = 10'd0;
      vid.bit_on = 1'b0;
      modelReset();
      repeat (3) @(posedge vga_clk);
      #1;
      checkOutput("rst_paddle_y", int'(vid.paddle_y), 240);
      checkOutput("rst_dir_up", int'(vid.dir_up), 0);
      checkOutput("rst_top_blocked", int'(vid.top_blocked), 0);
      checkOutput("rst_bottom_blocked", int'(vid.bottom_blocked), 0);
      checkOutput("rst_frame_tick", int'(vid.frame_tick), 0);
      Reset = 1'b0;
      repeat (3) @(posedge vga_clk);
      #1;

      // Auto-bounce down to the bottom limit and turn.
      repeat (199) applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t1_y_199", int'(vid.paddle_y), 439);
      checkOutput("t1_dir_199", int'(vid.dir_up), 1);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t1_y_200", int'(vid.paddle_y), 438);

      // Reach y=41 going up, then bounce off the top limit in AUTO.
      doReset();
      repeat (199) applyStimulus(1, 1, 0, 0, 0);
      checkOutput("t2_y_start", int'(vid.paddle_y), 41);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t2_y_top", int'(vid.paddle_y), 40);
      checkOutput("t2_dir_top", int'(vid.dir_up), 0);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t2_y_back", int'(vid.paddle_y), 41);

      // Manual: both keys hold, then key_up saturates at the top.
      doReset();
      repeat (5) applyStimulus(1, 1, 1, 0, 0);
      checkOutput("t3_both_hold", int'(vid.paddle_y), 240);
      repeat (250) applyStimulus(1, 1, 0, 0, 0);
      checkOutput("t3_clamp_top", int'(vid.paddle_y), 40);

      // Tracking: deadband hold, follow down, then follow up.
      doReset();
      applyStimulus(2, 0, 0, 243, 0);
      checkOutput("t4_deadband", int'(vid.paddle_y), 240);
      repeat (10) applyStimulus(2, 0, 0, 300, 0);
      checkOutput("t4_follow_dn", int'(vid.paddle_y), 250);
      repeat (3) applyStimulus(2, 0, 0, 100, 0);
      checkOutput("t4_follow_up", int'(vid.paddle_y), 247);

      // An obstacle just below the paddle reverses AUTO without moving.
      doReset();
      applyStimulus(0, 0, 0, 0, 2);
      checkOutput("t5_bottom_blocked", int'(vid.bottom_blocked), 1);
      checkOutput("t5_dir_up", int'(vid.dir_up), 1);
      checkOutput("t5_y_hold", int'(vid.paddle_y), 240);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t5_y_up", int'(vid.paddle_y), 239);

      // Reset between frame_clk edge and tick; strobe held high across release.
      doReset();
      applyStimulus(0, 0, 0, 0, 0);
      @(posedge vga_clk); #1;
      frame_clk = 1'b1;
      repeat (2) @(posedge vga_clk);
      #1;
      seen0 = tick_seen;
      Reset = 1'b1;
      modelReset();
      repeat (3) @(posedge vga_clk);
      #1;
      checkOutput("t6_rst_y", int'(vid.paddle_y), 240);
      checkOutput("t6_rst_dir", int'(vid.dir_up), 0);
      checkOutput("t6_rst_blk", int'(vid.top_blocked) + int'(vid.bottom_blocked), 0);
      Reset = 1'b0;
      repeat (12) @(posedge vga_clk);
      #1;
      checkOutput("t6_no_tick", tick_seen - seen0, 0);
      frame_clk = 1'b0;
      repeat (4) @(posedge vga_clk);
      #1;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("t6_after", int'(vid.paddle_y), 241);

      // Randomised frames across all modes with obstacle traffic.
      doReset();
      repeat (120) begin
         applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 479)), 1);
      end

      checkOutput("paddle_x", int'(vid.paddle_x), X_POS);
      checkOutput("paddle_s", int'(vid.paddle_s), HALF_H);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
